// File: rtl/uart_bridge_pkg.sv
// rtl/uart_bridge_pkg.sv - shared opcodes, widths and decoder state encoding for the UART-to-Wishbone bridge
package uart_bridge_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [7:0] OP_WRITE = 8'hA5;
    localparam logic [7:0] OP_READ  = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_CSUM,
        ST_ISSUE
    } state_t;
endpackage

// File: rtl/uart_cmd_timeout.sv
// rtl/uart_cmd_timeout.sv - inter-byte idle counter that flags an abandoned frame
module uart_cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // A byte on the expiry cycle clears the count instead of expiring
    assign expire = enable && !clear && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear || expire) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - UART byte stream to registered read/write request; optional checksum via UART_CMD_CHECKSUM_EN
module uart_cmd_decoder
    import uart_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        i_data,
    input  logic              i_data_valid,
    output logic              o_start_rx,
    output logic              o_req_valid,
    output logic              o_req_we,
    output logic [ADDR_W-1:0] o_req_addr,
    output logic [DATA_W-1:0] o_req_wdata,
    input  logic              i_req_ready,
    output logic              o_frame_err,
    output logic              o_overrun
);
`ifdef UART_CMD_CHECKSUM_EN
    localparam state_t AFTER_PAYLOAD = ST_CSUM;
`else
    localparam state_t AFTER_PAYLOAD = ST_ISSUE;
`endif

    state_t            state, state_n;
    logic [1:0]        byte_cnt, byte_cnt_n;
    logic              we, we_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [DATA_W-1:0] wdata, wdata_n;
    logic              err_n, ovr_n;
    logic              in_frame, expire;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]        csum, csum_n;
`endif

    assign in_frame = (state == ST_ADDR) || (state == ST_DATA) || (state == ST_CSUM);

    uart_cmd_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (i_data_valid || !in_frame),
        .enable (in_frame),
        .expire (expire)
    );

    always_comb begin
        state_n    = state;
        byte_cnt_n = byte_cnt;
        we_n       = we;
        addr_n     = addr;
        wdata_n    = wdata;
        err_n      = 1'b0;
        ovr_n      = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
        csum_n     = csum;
        if (i_data_valid && (state == ST_ADDR || state == ST_DATA)) begin
            csum_n = csum ^ i_data;
        end
`endif
        case (state)
            ST_IDLE: begin
                if (i_data_valid) begin
                    if (i_data == OP_WRITE || i_data == OP_READ) begin
                        we_n       = (i_data == OP_WRITE);
                        byte_cnt_n = 2'd0;
                        addr_n     = '0;
                        wdata_n    = '0;
                        state_n    = ST_ADDR;
`ifdef UART_CMD_CHECKSUM_EN
                        csum_n     = i_data;
`endif
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (i_data_valid) begin
                    addr_n     = {addr[ADDR_W-9:0], i_data};
                    byte_cnt_n = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        state_n = we ? ST_DATA : AFTER_PAYLOAD;
                    end
                end else if (expire) begin
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (i_data_valid) begin
                    wdata_n    = {wdata[DATA_W-9:0], i_data};
                    byte_cnt_n = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        state_n = AFTER_PAYLOAD;
                    end
                end else if (expire) begin
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            ST_CSUM: begin
                if (i_data_valid) begin
                    if (i_data == csum) begin
                        state_n = ST_ISSUE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = ST_IDLE;
                    end
                end else if (expire) begin
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end
            end
`endif
            ST_ISSUE: begin
                // Receiver may already have been mid-byte when start_rx fell
                ovr_n = i_data_valid;
                if (i_req_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            byte_cnt    <= 2'd0;
            we          <= 1'b0;
            addr        <= '0;
            wdata       <= '0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
            o_req_valid <= 1'b0;
            o_start_rx  <= 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
            csum        <= 8'h00;
`endif
        end else begin
            state       <= state_n;
            byte_cnt    <= byte_cnt_n;
            we          <= we_n;
            addr        <= addr_n;
            wdata       <= wdata_n;
            o_frame_err <= err_n;
            o_overrun   <= ovr_n;
            o_req_valid <= (state_n == ST_ISSUE);
            o_start_rx  <= (state_n != ST_ISSUE);
`ifdef UART_CMD_CHECKSUM_EN
            csum        <= csum_n;
`endif
        end
    end

    assign o_req_we    = we;
    assign o_req_addr  = addr;
    assign o_req_wdata = wdata;
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb/tb_uart_cmd_decoder.sv - self-checking bench for uart_cmd_decoder with a request scoreboard
module tb_uart_cmd_decoder;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  i_data;
    logic        i_data_valid;
    logic        o_start_rx;
    logic        o_req_valid;
    logic        o_req_we;
    logic [31:0] o_req_addr;
    logic [31:0] o_req_wdata;
    logic        i_req_ready;
    logic        o_frame_err;
    logic        o_overrun;

    always #5 clk = ~clk;

    uart_cmd_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_start_rx   (o_start_rx),
        .o_req_valid  (o_req_valid),
        .o_req_we     (o_req_we),
        .o_req_addr   (o_req_addr),
        .o_req_wdata  (o_req_wdata),
        .i_req_ready  (i_req_ready),
        .o_frame_err  (o_frame_err),
        .o_overrun    (o_overrun)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   err_seen = 0;
    int   ovr_seen = 0;
    int   hs_seen = 0;
    bit   mon_en = 1'b0;
    logic prev_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every valid cycle must present the oldest outstanding request
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("start_rx_is_not_valid", o_start_rx, !o_req_valid);
            chk("err_pulse_width", o_frame_err & prev_err, 0);
            if (o_req_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got addr %0h expected no request", o_req_addr);
                end else begin
                    chk("req_we", o_req_we, exp_q[0].we);
                    chk("req_addr", o_req_addr, exp_q[0].addr);
                    chk("req_wdata", o_req_wdata, exp_q[0].wdata);
                    if (i_req_ready) begin
                        void'(exp_q.pop_front());
                        hs_seen++;
                    end
                end
            end
            if (o_frame_err) err_seen++;
            if (o_overrun) ovr_seen++;
            prev_err = o_frame_err;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_data       = b;
        i_data_valid = 1'b1;
        @(posedge clk);
        #1;
        i_data_valid = 1'b0;
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] b[$]);
        logic [7:0] x = 8'h00;
        foreach (b[i]) x ^= b[i];
        return x;
    endfunction

    function automatic void build(input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, output logic [7:0] b[$]);
        b = {};
        b.push_back(we ? 8'hA5 : 8'h5A);
        for (int i = 3; i >= 0; i--) b.push_back(addr[8*i +: 8]);
        if (we) for (int i = 3; i >= 0; i--) b.push_back(wdata[8*i +: 8]);
    endfunction

    task automatic send_frame(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input int gap);
        logic [7:0] b[$];
        build(we, addr, wdata, b);
`ifdef UART_CMD_CHECKSUM_EN
        b.push_back(xsum(b));
`endif
        exp_q.push_back({we, addr, we ? wdata : 32'h0});
        foreach (b[i]) begin
            if (i != 0) idle(gap);
            send_byte(b[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] fb[$];
        int exp_err;
        rst = 1'b1;
        i_data = 8'h00;
        i_data_valid = 1'b0;
        i_req_ready = 1'b0;
        idle(2);
        chk("rst_valid", o_req_valid, 0);
        chk("rst_we", o_req_we, 0);
        chk("rst_addr", o_req_addr, 0);
        chk("rst_wdata", o_req_wdata, 0);
        chk("rst_err", o_frame_err, 0);
        chk("rst_ovr", o_overrun, 0);
        chk("rst_start_rx", o_start_rx, 1);
        rst = 1'b0;
        mon_en = 1'b1;

        // Checksum model pinned against hand-XORed values
        build(1'b1, 32'h10000004, 32'hDEADBEEF, fb);
        chk("xsum_write", xsum(fb), 8'h93);
        build(1'b0, 32'h00000020, 32'h0, fb);
        chk("xsum_read", xsum(fb), 8'h7A);

        // Write, ready held low, stray byte during ISSUE
        send_frame(1'b1, 32'h10000004, 32'hDEADBEEF, 0);
        chk("wr_valid_latency", o_req_valid, 1);
        chk("wr_we", o_req_we, 1);
        chk("wr_addr", o_req_addr, 32'h10000004);
        chk("wr_wdata", o_req_wdata, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("wr_hold_valid", o_req_valid, 1);
            chk("wr_hold_start_rx", o_start_rx, 0);
        end
        send_byte(8'h77);
        chk("ovr_pulse", o_overrun, 1);
        chk("ovr_addr", o_req_addr, 32'h10000004);
        chk("ovr_valid", o_req_valid, 1);
        idle(1);
        chk("ovr_end", o_overrun, 0);
        i_req_ready = 1'b1;
        idle(1);
        chk("wr_done_valid", o_req_valid, 0);
        chk("wr_done_start_rx", o_start_rx, 1);

        // Read accepted immediately, then back-to-back read
        send_frame(1'b0, 32'h00000020, 32'h0, 0);
        chk("rd_valid", o_req_valid, 1);
        chk("rd_addr", o_req_addr, 32'h00000020);
        chk("rd_wdata", o_req_wdata, 0);
        idle(1);
        chk("rd_one_cycle", o_req_valid, 0);
        send_frame(1'b0, 32'hCAFE0000, 32'h0, 0);
        chk("b2b_valid", o_req_valid, 1);
        idle(1);

        // Bad opcode then a good read
        send_byte(8'h33);
        chk("badop_err", o_frame_err, 1);
        chk("badop_no_req", o_req_valid, 0);
        idle(1);
        chk("badop_err_end", o_frame_err, 0);
        send_frame(1'b0, 32'h00000044, 32'h0, 0);
        chk("badop_next_valid", o_req_valid, 1);
        idle(1);

        // Timeout: error exactly TO cycles after last byte
        send_byte(8'hA5);
        send_byte(8'h12);
        idle(TO - 1);
        chk("to_not_yet", o_frame_err, 0);
        idle(1);
        chk("to_err", o_frame_err, 1);
        idle(1);
        chk("to_err_end", o_frame_err, 0);
        chk("to_no_req", o_req_valid, 0);
        send_frame(1'b1, 32'h0000ABCD, 32'h01020304, 0);
        chk("to_next_valid", o_req_valid, 1);
        idle(1);

        // Byte landing on the expiry cycle keeps the frame alive
        send_frame(1'b0, 32'h00000001, 32'h0, TO - 1);
        chk("edge_valid", o_req_valid, 1);
        idle(1);

`ifdef UART_CMD_CHECKSUM_EN
        send_byte(8'h5A);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h20);
        send_byte(8'h00);
        chk("csum_err", o_frame_err, 1);
        chk("csum_no_req", o_req_valid, 0);
        idle(1);
`endif

        // Reset mid-frame
        send_byte(8'hA5);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b1;
        idle(1);
        chk("mid_rst_valid", o_req_valid, 0);
        chk("mid_rst_addr", o_req_addr, 0);
        chk("mid_rst_we", o_req_we, 0);
        chk("mid_rst_start_rx", o_start_rx, 1);
        rst = 1'b0;
        send_frame(1'b0, 32'h76543210, 32'h0, 0);
        chk("post_rst_valid", o_req_valid, 1);
        chk("post_rst_addr", o_req_addr, 32'h76543210);
        idle(3);

        exp_err = 2;
`ifdef UART_CMD_CHECKSUM_EN
        exp_err = 3;
`endif
        chk("queue_drained", exp_q.size(), 0);
        chk("handshakes", hs_seen, 7);
        chk("overruns", ovr_seen, 1);
        chk("frame_errs", err_seen, exp_err);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
